uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares the single UART transmit path (TX FIFO write port) between N_REQ
//   byte-stream requesters. Arbitration is round-robin and message granular:
//   once granted, a requester keeps the FIFO until it writes the last byte of
//   its message, hits the per-grant burst limit, or withdraws its request.
//
// State table:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no owner; pick next requester starting at rr_ptr (with wrap)
//   XFER    | grant held; owner byte written whenever FIFO has room
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   req         in   [N_REQ]    requester i has a valid byte on its lane
//   req_data    in   [8*N_REQ]  byte of requester i on bits [8i+7:8i]
//   req_last    in   [N_REQ]    current byte of requester i ends its message
//   req_ack     out  [N_REQ]    pulse: requester i's byte written this cycle
//   fifo_full   in   TX FIFO full flag
//   fifo_wr_en  out  TX FIFO write strobe
//   fifo_data   out  [8]        TX FIFO write data
//   grant       out  [N_REQ]    one-hot current owner, zero when idle
//   busy        out  high while a grant is held
//
// Parameters:
//   N_REQ      number of requesters (2..8)
//   MAX_BURST  bytes written per grant before forced rotation (1..255)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ack,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_data,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int          PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  MAX_BURST_C = 8'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;

  // Owner decode from the registered one-hot grant.
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_req;
  logic               owner_last;
  logic [7:0]         owner_data;

  // Round-robin pick.
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  logic               wr;
  logic [7:0]         burst_inc;

  always_comb begin
    owner_idx  = '0;
    owner_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = req_data[8*i +: 8];
      end
    end
    owner_req  = |(req & grant_q);
    owner_last = |(req_last & grant_q);
  end

  // Two passes give "first set bit at or above rr_ptr, else first set bit
  // overall", which is the wrap-around scan without modulo arithmetic.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
      end
    end
  end

  assign burst_inc = burst_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = N_REQ'(1) << pick_idx;
          burst_cnt_d = 8'd0;
          state_d     = ST_XFER;
        end
      end

      ST_XFER: begin
        if (!owner_req) begin
          // Owner withdrew: give up the FIFO, nothing written this cycle.
          state_d     = ST_IDLE;
          grant_d     = '0;
          burst_cnt_d = 8'd0;
          rr_ptr_d    = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
        end else if (!fifo_full) begin
          wr          = 1'b1;
          burst_cnt_d = burst_inc;
          if (owner_last || (burst_inc == MAX_BURST_C)) begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            burst_cnt_d = 8'd0;
            rr_ptr_d    = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
          end
        end
        // fifo_full with the owner still requesting: hold everything.
      end

      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Data and ack are gated by the write so the FIFO bus stays quiet
  // whenever no byte is being accepted.
  assign fifo_wr_en = wr;
  assign fifo_data  = wr ? owner_data : 8'h00;
  assign req_ack    = wr ? grant_q : '0;
  assign grant      = grant_q;
  assign busy       = (state_q == ST_XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic [3:0]  grant;
  logic        busy;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant      (grant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester byte queues: {last, data}.
  logic [8:0] rmem [4][128];
  int         rhead [4];
  int         rtail [4];
  logic [3:0] en;

  // Scoreboard: {requester index, byte} in expected write order.
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic update_drive();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && (rhead[i] != rtail[i])) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = rmem[i][rhead[i]][7:0];
        req_last[i]       = rmem[i][rhead[i]][8];
      end else begin
        req[i]            = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input int cnt, input logic [7:0] base, input bit last_end);
    for (int k = 0; k < cnt; k++) begin
      rmem[r][rtail[r]] = {(last_end && (k == cnt - 1)), 8'(base + 8'(k))};
      rtail[r]++;
    end
    update_drive();
  endtask

  task automatic push_exp(input int r, input logic [7:0] base, input int cnt);
    for (int k = 0; k < cnt; k++)
      exp_q.push_back({2'(r), 8'(base + 8'(k))});
  endtask

  // One clock: sample outputs at the falling edge, retire acked bytes after
  // the rising edge, then present the next bytes. Entered/left at posedge+1.
  task automatic tick();
    logic [3:0] ack_s;
    logic [9:0] e;
    @(negedge clk);
    ack_s = req_ack;
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(fifo_data), 32'(e[7:0]));
        check("wr_ack", 32'(req_ack), 32'(4'b0001 << e[9:8]));
      end
    end else begin
      check("nowrite_ack", 32'(req_ack), 32'h0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (ack_s[i]) rhead[i]++;
    update_drive();
  endtask

  task automatic drain(input int max_cyc, output int n);
    n = 0;
    while ((exp_q.size() != 0) && (n < max_cyc)) begin
      tick();
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    en = 4'hF;
    exp_q.delete();
    update_drive();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    clear_reqs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    req_last  = '0;
    clear_reqs();

    // Reset state
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_data", 32'(fifo_data), 32'h0);
    check("rst_ack", 32'(req_ack), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester: 41 42 43(last)
    load(0, 3, 8'h41, 1'b1);
    push_exp(0, 8'h41, 3);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    drain(20, n);
    check("t1_consecutive", 32'(n), 32'd3);
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_grant_after", 32'(grant), 32'h0);

    // Round robin from rr_ptr=0: 0,1,2,3,0 with 2-byte messages
    do_reset();
    load(0, 2, 8'h10, 1'b1);
    load(0, 2, 8'h18, 1'b1);
    load(1, 2, 8'h20, 1'b1);
    load(2, 2, 8'h30, 1'b1);
    load(3, 2, 8'h40, 1'b1);
    push_exp(0, 8'h10, 2);
    push_exp(1, 8'h20, 2);
    push_exp(2, 8'h30, 2);
    push_exp(3, 8'h40, 2);
    push_exp(0, 8'h18, 2);
    drain(60, n);
    check("t2_cycles", 32'(n), 32'd15);
    check("t2_busy_after", 32'(busy), 32'h0);

    // Burst limit: rr_ptr=1, requester 2 streams 20 bytes, requester 3 waits
    load(2, 20, 8'h80, 1'b0);
    load(3, 2, 8'hC0, 1'b1);
    push_exp(2, 8'h80, 16);
    push_exp(3, 8'hC0, 2);
    push_exp(2, 8'h90, 4);
    drain(80, n);
    check("t3_cycles", 32'(n), 32'd25);
    check("t3_still_busy", 32'(busy), 32'h1);
    tick();
    check("t3_withdraw_busy", 32'(busy), 32'h0);

    // Back-pressure: rr_ptr=3, requester 3 sends 4 bytes, full for 5 cycles
    load(3, 4, 8'h50, 1'b1);
    push_exp(3, 8'h50, 4);
    tick();
    check("t4_grant", 32'(grant), 32'h8);
    tick();
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_full_wr_en", 32'(fifo_wr_en), 32'h0);
      check("t4_full_ack", 32'(req_ack), 32'h0);
      check("t4_full_grant", 32'(grant), 32'h8);
    end
    check("t4_pending", 32'(exp_q.size()), 32'd2);
    fifo_full = 1'b0;
    drain(20, n);
    check("t4_resume_cycles", 32'(n), 32'd2);
    check("t4_busy_after", 32'(busy), 32'h0);

    // Withdrawal: rr_ptr=0, requester 1 drops req after one byte
    load(1, 3, 8'h60, 1'b1);
    push_exp(1, 8'h60, 1);
    tick();
    check("t5_grant", 32'(grant), 32'h2);
    tick();
    en[1] = 1'b0;
    load(0, 1, 8'h70, 1'b1);
    load(2, 1, 8'h72, 1'b1);
    push_exp(2, 8'h72, 1);
    push_exp(0, 8'h70, 1);
    tick();
    check("t5_release_busy", 32'(busy), 32'h0);
    check("t5_release_grant", 32'(grant), 32'h0);
    drain(20, n);
    check("t5_cycles", 32'(n), 32'd4);
    rhead[1] = rtail[1];
    en[1]    = 1'b1;
    update_drive();

    // Reset mid-burst: rr_ptr=1, requester 2 granted, reset after 2 bytes
    load(2, 4, 8'hA0, 1'b0);
    push_exp(2, 8'hA0, 2);
    tick();
    check("t6_grant", 32'(grant), 32'h4);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("t6_rst_ack", 32'(req_ack), 32'h0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'h0);
    rhead[2] = rtail[2];
    update_drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    load(3, 1, 8'hB3, 1'b1);
    load(0, 1, 8'hB0, 1'b1);
    push_exp(0, 8'hB0, 1);
    push_exp(3, 8'hB3, 1);
    drain(20, n);
    check("t6_cycles", 32'(n), 32'd4);
    tick();
    check("t6_final_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
